fifo_uart_tx: RTL and testbench

Drain side of the fifo_ram buffer. The block pops bytes from the FIFO read port and serialises each one onto a single UART line as 8N1, LSB first. It sits between the FIFO outputs (data_out, empty) and the board TX pin, and drives the FIFO pop input.

---
 rtl/fifo_uart_tx.sv | 104 ++++++++++
 tb/tb_fifo_uart_tx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-drain UART transmitter: pops one byte per frame from the FIFO read port
// and shifts it out on tx as 8N1, LSB first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       pop,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             tx_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        cnt_next = '0;
        if (enable && !fifo_empty) state_next = FETCH;
      end
      FETCH: begin
        pop        = 1'b1;
        shift_next = fifo_data;
        cnt_next   = '0;
        state_next = START;
      end
      START: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          shift_next = shift >> 1;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // tx is registered from the state being entered so it changes on that edge
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, tx frame decoder and scoreboard of
// expected bytes, one task per scenario.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clock      = 1'b0;
  logic       reset      = 1'b1;
  logic       enable     = 1'b0;
  logic [7:0] fifo_data  = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       pop, tx, busy;

  logic       push_en   = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fq [$];
  logic [7:0] exp_q [$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  logic       mon_active = 1'b0;
  logic [5:0] mon_off    = 6'd0;
  logic [9:0] mon_bits   = 10'd0;
  int         mon_start  = 0;
  logic [9:0] rec_bits  [0:31];
  int         rec_start [0:31];
  int         rx_wr    = 0;
  int         rx_rd    = 0;
  int         pop_cnt  = 0;
  int         bad_pop  = 0;
  int         busy_cnt = 0;
  int         low_cnt  = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .pop        (pop),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // FIFO with registered head/empty, like a synchronous-read RAM
  always @(posedge clock) begin
    if (pop && fq.size() > 0) void'(fq.pop_front());
    if (push_en) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // Frame decoder: samples tx at bit centres, counts pops/busy/low cycles
  always @(negedge clock) begin
    if (!reset) begin
      mon_active <= 1'b0;
    end else begin
      if (pop) pop_cnt <= pop_cnt + 1;
      if (pop && fifo_empty) bad_pop <= bad_pop + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (!tx) low_cnt <= low_cnt + 1;
      if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active <= 1'b1;
          mon_off    <= 6'd1;
          mon_start  <= cyc;
        end
      end else begin
        if (mon_off[1:0] == 2'd2) mon_bits[mon_off[5:2]] <= tx;
        if (mon_off == 6'd38) begin
          rec_bits[rx_wr[4:0]]  <= {tx, mon_bits[8:0]};
          rec_start[rx_wr[4:0]] <= mon_start;
          rx_wr      <= rx_wr + 1;
          mon_active <= 1'b0;
        end else begin
          mon_off <= mon_off + 6'd1;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_out, output int at_cyc);
    @(negedge clock);
    push_en   = 1'b1;
    push_data = b;
    at_cyc    = cyc;
    if (expect_out) exp_q.push_back(b);
    @(negedge clock);
    push_en = 1'b0;
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_wr > rx_rd) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_active(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mon_active) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (pop !== 1'b0)  begin n_fail++; $display("FAIL reset_pop: got %b want 0", pop); end
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (tx !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL idle_after_reset: got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_single_byte;
    int c, p0, b0;
    bit ok;
    logic [7:0] e;
    p0 = pop_cnt; b0 = busy_cnt;
    push(8'hA5, 1'b1, c);
    wait_frame(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got no frame want 1 frame"); end
    else begin
      e = exp_q.pop_front();
      if (rec_bits[rx_rd[4:0]] !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL single_bits: got %b want %b", rec_bits[rx_rd[4:0]], {1'b1, e, 1'b0});
      end
      rx_rd++;
    end
    repeat (10) @(negedge clock);
    n_cmp++; if (pop_cnt - p0 != 1)   begin n_fail++; $display("FAIL single_pops: got %0d want 1", pop_cnt - p0); end
    n_cmp++; if (busy_cnt - b0 != 41) begin n_fail++; $display("FAIL single_busy_len: got %0d want 41", busy_cnt - b0); end
    n_cmp++; if (tx !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL single_idle: got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_back_to_back;
    int c, p0, prev;
    bit ok;
    logic [7:0] e;
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'hFF, 8'h3C};
    p0 = pop_cnt; prev = 0;
    foreach (bytes[i]) push(bytes[i], 1'b1, c);
    for (int i = 0; i < 3; i++) begin
      wait_frame(100, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got no frame %0d want frame", i); end
      else begin
        e = exp_q.pop_front();
        if (rec_bits[rx_rd[4:0]] !== {1'b1, e, 1'b0}) begin
          n_fail++; $display("FAIL b2b_bits: got %b want %b", rec_bits[rx_rd[4:0]], {1'b1, e, 1'b0});
        end
        if (i > 0) begin
          n_cmp++;
          if (rec_start[rx_rd[4:0]] - prev != 10*CPB + 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", rec_start[rx_rd[4:0]] - prev, 10*CPB + 2);
          end
        end
        prev = rec_start[rx_rd[4:0]];
        rx_rd++;
      end
    end
    repeat (10) @(negedge clock);
    n_cmp++; if (pop_cnt - p0 != 3) begin n_fail++; $display("FAIL b2b_pops: got %0d want 3", pop_cnt - p0); end
    n_cmp++; if (fifo_empty !== 1'b1 || tx !== 1'b1)
      begin n_fail++; $display("FAIL b2b_idle: got empty=%b tx=%b want 1 1", fifo_empty, tx); end
  endtask

  task automatic test_empty;
    int p0, b0, l0;
    p0 = pop_cnt; b0 = busy_cnt; l0 = low_cnt;
    repeat (200) @(negedge clock);
    n_cmp++; if (pop_cnt - p0 != 0)  begin n_fail++; $display("FAIL empty_pops: got %0d want 0", pop_cnt - p0); end
    n_cmp++; if (busy_cnt - b0 != 0) begin n_fail++; $display("FAIL empty_busy: got %0d want 0", busy_cnt - b0); end
    n_cmp++; if (low_cnt - l0 != 0)  begin n_fail++; $display("FAIL empty_tx_low: got %0d want 0", low_cnt - l0); end
    n_cmp++; if (rx_wr != rx_rd)     begin n_fail++; $display("FAIL empty_frames: got %0d want 0", rx_wr - rx_rd); end
  endtask

  task automatic test_enable_gating;
    int c, p0;
    bit ok;
    logic [7:0] e;
    p0 = pop_cnt;
    push(8'h81, 1'b1, c);
    push(8'h42, 1'b1, c);
    wait_active(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL gate_start_timeout: got no start want start"); end
    repeat (16) @(negedge clock);
    enable = 1'b0;
    wait_frame(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL gate_frame_timeout: got no frame want frame"); end
    else begin
      e = exp_q.pop_front();
      if (rec_bits[rx_rd[4:0]] !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL gate_bits: got %b want %b", rec_bits[rx_rd[4:0]], {1'b1, e, 1'b0});
      end
      rx_rd++;
    end
    repeat (60) @(negedge clock);
    n_cmp++; if (pop_cnt - p0 != 1) begin n_fail++; $display("FAIL gate_pops: got %0d want 1", pop_cnt - p0); end
    n_cmp++; if (busy !== 1'b0 || rx_wr != rx_rd || fifo_empty !== 1'b0)
      begin n_fail++; $display("FAIL gate_hold: got busy=%b frames=%0d empty=%b want 0 0 0", busy, rx_wr - rx_rd, fifo_empty); end
    enable = 1'b1;
    c = cyc;
    wait_frame(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL gate_resume_timeout: got no frame want frame"); end
    else begin
      e = exp_q.pop_front();
      if (rec_bits[rx_rd[4:0]] !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL gate_resume_bits: got %b want %b", rec_bits[rx_rd[4:0]], {1'b1, e, 1'b0});
      end
      n_cmp++;
      if (rec_start[rx_rd[4:0]] != c + 2) begin
        n_fail++; $display("FAIL gate_resume_latency: got %0d want %0d", rec_start[rx_rd[4:0]] - c, 2);
      end
      rx_rd++;
    end
    repeat (10) @(negedge clock);
  endtask

  task automatic test_async_reset;
    int c, p0;
    bit ok;
    logic [7:0] e;
    p0 = pop_cnt;
    push(8'h5A, 1'b0, c);
    push(8'h96, 1'b1, c);
    wait_active(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL areset_start_timeout: got no start want start"); end
    repeat (16) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL areset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_cmp++; if (pop !== 1'b0)  begin n_fail++; $display("FAIL areset_pop: got %b want 0", pop); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_frame(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL areset_frame_timeout: got no frame want frame"); end
    else begin
      e = exp_q.pop_front();
      if (rec_bits[rx_rd[4:0]] !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL areset_bits: got %b want %b", rec_bits[rx_rd[4:0]], {1'b1, e, 1'b0});
      end
      rx_rd++;
    end
    repeat (10) @(negedge clock);
    n_cmp++; if (pop_cnt - p0 != 2 || fifo_empty !== 1'b1)
      begin n_fail++; $display("FAIL areset_pops: got %0d empty=%b want 2 empty=1", pop_cnt - p0, fifo_empty); end
  endtask

  task automatic test_pop_race;
    int c, p0;
    bit ok;
    logic [7:0] e;
    p0 = pop_cnt;
    push(8'h7E, 1'b1, c);
    wait_frame(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL race_timeout: got no frame want frame"); end
    else begin
      e = exp_q.pop_front();
      if (rec_bits[rx_rd[4:0]] !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL race_bits: got %b want %b", rec_bits[rx_rd[4:0]], {1'b1, e, 1'b0});
      end
      rx_rd++;
    end
    repeat (8) @(negedge clock);
    n_cmp++; if (pop_cnt - p0 != 1 || busy !== 1'b0 || fifo_empty !== 1'b1)
      begin n_fail++; $display("FAIL race_idle: got pops=%0d busy=%b empty=%b want 1 0 1", pop_cnt - p0, busy, fifo_empty); end
    push(8'h33, 1'b1, c);
    wait_frame(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL race_push_timeout: got no frame want frame"); end
    else begin
      e = exp_q.pop_front();
      if (rec_bits[rx_rd[4:0]] !== {1'b1, e, 1'b0}) begin
        n_fail++; $display("FAIL race_push_bits: got %b want %b", rec_bits[rx_rd[4:0]], {1'b1, e, 1'b0});
      end
      n_cmp++;
      if (rec_start[rx_rd[4:0]] != c + 3) begin
        n_fail++; $display("FAIL race_push_latency: got %0d want %0d", rec_start[rx_rd[4:0]] - c, 3);
      end
      rx_rd++;
    end
    repeat (10) @(negedge clock);
    n_cmp++; if (pop_cnt - p0 != 2) begin n_fail++; $display("FAIL race_pops: got %0d want 2", pop_cnt - p0); end
  endtask

  task automatic test_no_empty_pop;
    n_cmp++; if (bad_pop != 0) begin n_fail++; $display("FAIL pop_while_empty: got %0d want 0", bad_pop); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_enable_gating();
    test_async_reset();
    test_pop_race();
    test_no_empty_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
